// File: rtl/axis_frame_aligner_pkg.sv
// rtl/axis_frame_aligner_pkg.sv - shared types and sizing helpers for the frame aligner
package axis_frame_aligner_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    PAD
  } aligner_state_t;

  // Pixel counter width; a one-beat frame still needs a 1-bit counter
  function automatic int pix_width(input int width, input int height);
    int total;
    total = width * height;
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry register slice with registered space indication
module axis_skid_buffer #(
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic [DW-1:0] main_q, skid_q, main_d, skid_d;
  logic          main_v_q, skid_v_q, main_v_d, skid_v_d;
  logic          ready_q;
  logic          rd;

  assign rd = main_v_q && out_ready;

  // Next occupancy: the output slot refills from the skid slot first, then from the write
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (rd) begin
      if (skid_v_q) begin
        main_d = skid_q;
        if (wr_en) skid_d = wr_data;
        else       skid_v_d = 1'b0;
      end else if (wr_en) begin
        main_d = wr_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (wr_en) begin
      if (!main_v_q) begin
        main_d   = wr_data;
        main_v_d = 1'b1;
      end else begin
        skid_d   = wr_data;
        skid_v_d = 1'b1;
      end
    end
  end

  // Register both slots; ready is derived from next occupancy so it never depends on out_ready this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= !(main_v_d && skid_v_d);
    end
  end

  assign ready     = ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

endmodule

// File: rtl/axis_frame_aligner.sv
// rtl/axis_frame_aligner.sv - forces every forwarded frame to exactly WIDTH*HEIGHT beats
module axis_frame_aligner
  import axis_frame_aligner_pkg::*;
#(
  parameter int                    WIDTH      = 128,
  parameter int                    HEIGHT     = 100,
  parameter int                    DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  early_sof_err,
  output logic                  drop_err,
  output logic [15:0]           frame_cnt
);

  localparam int                TOTAL = WIDTH * HEIGHT;
  localparam int                PIX_W = pix_width(WIDTH, HEIGHT);
  localparam logic [PIX_W-1:0]  LAST  = PIX_W'(TOTAL - 1);

  aligner_state_t        state;
  logic [PIX_W-1:0]      pix;
  logic                  space;
  logic                  s_accept;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_user;
  logic                  wr_last;
  logic [DATA_WIDTH+1:0] m_payload;
  logic                  unused_tlast;

  // Source framing is regenerated from pix, so the incoming end-of-frame marker is not needed
  assign unused_tlast = s_axis_tlast;

  // Accept control and buffer write path; an early SOF in PASS is refused so it survives into the next frame
  always_comb begin
    s_axis_tready = space && (state != PAD) && !(state == PASS && s_axis_tvalid && s_axis_tuser);
    s_accept      = s_axis_tvalid && s_axis_tready;
    wr_en         = 1'b0;
    wr_data       = s_axis_tdata;
    wr_user       = 1'b0;
    wr_last       = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (s_accept && s_axis_tuser) begin
          wr_en   = 1'b1;
          wr_user = 1'b1;
          wr_last = (TOTAL == 1);
        end
      end
      PASS: begin
        if (s_accept) begin
          wr_en   = 1'b1;
          wr_last = (pix == LAST);
        end
      end
      PAD: begin
        if (space) begin
          wr_en   = 1'b1;
          wr_data = PAD_VALUE;
          wr_last = (pix == LAST);
        end
      end
      default: ;
    endcase
  end

  // Frame state machine with registered error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_SOF;
      pix           <= '0;
      drop_err      <= 1'b0;
      early_sof_err <= 1'b0;
    end else begin
      drop_err      <= 1'b0;
      early_sof_err <= 1'b0;
      unique case (state)
        WAIT_SOF: begin
          if (s_accept) begin
            if (s_axis_tuser) begin
              if (TOTAL > 1) begin
                state <= PASS;
                pix   <= PIX_W'(1);
              end
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        PASS: begin
          if (s_accept) begin
            if (pix == LAST) begin
              state <= WAIT_SOF;
              pix   <= '0;
            end else begin
              pix <= pix + PIX_W'(1);
            end
          end else if (s_axis_tvalid && s_axis_tuser) begin
            early_sof_err <= 1'b1;
            state         <= PAD;
          end
        end
        PAD: begin
          if (space) begin
            if (pix == LAST) begin
              state <= WAIT_SOF;
              pix   <= '0;
            end else begin
              pix <= pix + PIX_W'(1);
            end
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  // Completed frames are counted when the downstream accepts the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  axis_skid_buffer #(
    .DW(DATA_WIDTH + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  ({wr_user, wr_last, wr_data}),
    .ready    (space),
    .out_valid(m_axis_tvalid),
    .out_data (m_payload),
    .out_ready(m_axis_tready)
  );

  assign m_axis_tuser = m_payload[DATA_WIDTH+1];
  assign m_axis_tlast = m_payload[DATA_WIDTH];
  assign m_axis_tdata = m_payload[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_frame_aligner.sv
// tb/tb_axis_frame_aligner.sv - directed self-checking bench for the frame aligner
module tb_axis_frame_aligner;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          early_sof_err;
  logic          drop_err;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] got[$];
  int            drop_cnt = 0;
  int            early_cnt = 0;
  int            stall_viol = 0;
  logic          stalled_prev = 1'b0;
  logic [DW+1:0] held = '0;
  logic          bp_en = 1'b0;

  axis_frame_aligner #(
    .WIDTH     (4),
    .HEIGHT    (2),
    .DATA_WIDTH(DW),
    .PAD_VALUE (24'h000000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .early_sof_err(early_sof_err),
    .drop_err     (drop_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      got.delete();
      drop_cnt     = 0;
      early_cnt    = 0;
      stall_viol   = 0;
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held))
        stall_viol++;
      if (m_axis_tvalid && m_axis_tready)
        got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      stalled_prev = m_axis_tvalid && !m_axis_tready;
      held         = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (drop_err)      drop_cnt++;
      if (early_sof_err) early_cnt++;
    end
  end

  function automatic logic [DW+1:0] beat(input logic u, input logic l, input logic [DW-1:0] d);
    return {u, l, d};
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic u);
    bit done = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) done = 1;
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h not accepted within 200 cycles", d);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) send_beat(base + DW'(i), i == 0);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (got.size() >= n) break;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got=%b exp=0", m_axis_tuser); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (early_sof_err !== 1'b0) begin errors++; $display("FAIL reset_early got=%b exp=0", early_sof_err); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_sready got=%b exp=0", s_axis_tready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL sready_before_edge got=%b exp=0", s_axis_tready); end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL sready_after_edge got=%b exp=1", s_axis_tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_frame();
    do_reset();
    send_frame(24'h01);
    wait_beats(8);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL clean_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL clean_beat%0d missing", i); end
      else if (got[i] !== beat(i == 0, i == 7, DW'(i + 1))) begin
        errors++; $display("FAIL clean_beat%0d got=%h exp=%h", i, got[i], beat(i == 0, i == 7, DW'(i + 1)));
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL clean_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL clean_drop got=%0d exp=0", drop_cnt); end
    checks++; if (early_cnt !== 0) begin errors++; $display("FAIL clean_early got=%0d exp=0", early_cnt); end
  endtask

  task automatic test_drop_junk();
    do_reset();
    send_beat(24'hAA, 1'b0);
    send_beat(24'hBB, 1'b0);
    send_beat(24'hCC, 1'b0);
    send_frame(24'h01);
    wait_beats(8);
    checks++; if (drop_cnt !== 3) begin errors++; $display("FAIL junk_drop got=%0d exp=3", drop_cnt); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL junk_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL junk_beat%0d missing", i); end
      else if (got[i] !== beat(i == 0, i == 7, DW'(i + 1))) begin
        errors++; $display("FAIL junk_beat%0d got=%h exp=%h", i, got[i], beat(i == 0, i == 7, DW'(i + 1)));
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL junk_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (early_cnt !== 0) begin errors++; $display("FAIL junk_early got=%0d exp=0", early_cnt); end
  endtask

  task automatic test_early_sof();
    logic [DW+1:0] exp_q[16];
    for (int i = 0; i < 5; i++) exp_q[i] = beat(i == 0, 1'b0, DW'(i + 1));
    exp_q[5] = beat(1'b0, 1'b0, 24'h0);
    exp_q[6] = beat(1'b0, 1'b0, 24'h0);
    exp_q[7] = beat(1'b0, 1'b1, 24'h0);
    for (int i = 8; i < 16; i++) exp_q[i] = beat(i == 8, i == 15, DW'(24'h11 + i - 8));
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(DW'(i + 1), i == 0);
    send_frame(24'h11);
    wait_beats(16);
    checks++; if (early_cnt !== 1) begin errors++; $display("FAIL early_pulses got=%0d exp=1", early_cnt); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL early_drop got=%0d exp=0", drop_cnt); end
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL early_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL early_beat%0d missing", i); end
      else if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL early_beat%0d got=%h exp=%h", i, got[i], exp_q[i]);
      end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL early_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    do_reset();
    send_frame(24'h01);
    wait_beats(8);
    bp_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL bp_beat%0d missing", i); end
      else if (got[i] !== beat(i == 0, i == 7, DW'(i + 1))) begin
        errors++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], beat(i == 0, i == 7, DW'(i + 1)));
      end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt got=%0d exp=1", frame_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(24'h21);
    send_frame(24'h31);
    wait_beats(16);
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL b2b_beat%0d missing", i); end
      else if (got[i] !== beat(i % 8 == 0, i % 8 == 7, (i < 8) ? DW'(24'h21 + i) : DW'(24'h31 + i - 8))) begin
        errors++; $display("FAIL b2b_beat%0d got=%h", i, got[i]);
      end
    end
    checks++; if (early_cnt !== 0) begin errors++; $display("FAIL b2b_early got=%0d exp=0", early_cnt); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(DW'(i + 1), i == 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 24'h0) begin errors++; $display("FAIL midrst_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if ({m_axis_tuser, m_axis_tlast} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b exp=00", {m_axis_tuser, m_axis_tlast}); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL midrst_sready got=%b exp=0", s_axis_tready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(24'h41);
    wait_beats(8);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL midrst_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL midrst_beat%0d missing", i); end
      else if (got[i] !== beat(i == 0, i == 7, DW'(24'h41 + i))) begin
        errors++; $display("FAIL midrst_beat%0d got=%h exp=%h", i, got[i], beat(i == 0, i == 7, DW'(24'h41 + i)));
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_post_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_drop_junk();
    test_early_sof();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_aligner.md
# axis_frame_aligner

Input-conditioning stage directly upstream of `barrel_distortion_correction`. It takes a raw RGB888 AXI4-Stream from the capture source and guarantees that every frame it forwards contains exactly WIDTH*HEIGHT beats, with `tuser` on the first beat and `tlast` on the last. It pads truncated frames, discards stray beats between frames, and reports alignment errors, so the correction core never sees a malformed frame.

## Interface
- WIDTH, 128, active pixels per line
- HEIGHT, 100, lines per frame
- DATA_WIDTH, 24, pixel width (RGB888)
- PAD_VALUE, 24'h000000, pixel value inserted when a frame is truncated
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  source pixel
- s_axis_tvalid  in  1  source beat valid
- s_axis_tuser  in  1  start of frame from the source (pixel 0)
- s_axis_tlast  in  1  source end-of-frame; ignored
- s_axis_tready  out  1  aligner can accept a beat
- m_axis_tdata  out  DATA_WIDTH  aligned pixel to the correction core
- m_axis_tvalid  out  1  output beat valid
- m_axis_tuser  out  1  regenerated start of frame
- m_axis_tlast  out  1  regenerated end of frame (pixel WIDTH*HEIGHT-1)
- m_axis_tready  in  1  downstream ready
- early_sof_err  out  1  one-cycle pulse: SOF seen before the frame completed
- drop_err  out  1  one-cycle pulse per discarded non-SOF beat
- frame_cnt  out  16  count of completed output frames; wraps at 16'hFFFF

## Operation
- TOTAL = WIDTH*HEIGHT.
- Pixel counter `pix`: $clog2(TOTAL) bits. It counts beats written into the output buffer for the current frame.
- The state machine has three states: WAIT_SOF, PASS and PAD.
- WAIT_SOF (reset state):
  - s_axis_tready = 1 whenever the output buffer can accept a beat.
  - An accepted beat with tuser=0 is dropped and pulses drop_err.
  - An accepted beat with tuser=1 is written as pixel 0 (tuser=1) and moves the FSM to PASS with pix=1.
- PASS:
  - Accepted beats with tuser=0 are written with pix incremented.
  - The beat written at pix=TOTAL-1 carries tlast=1. After it, the FSM goes to WAIT_SOF and pix resets to 0.
  - If tvalid&&tuser arrives with pix≠0, the beat is NOT consumed: s_axis_tready=0 in that cycle. early_sof_err pulses once and the FSM goes to PAD.
- PAD:
  - s_axis_tready=0.
  - Writes one PAD_VALUE beat per cycle of buffer space, until the beat at pix=TOTAL-1 (tlast=1) is written.
  - Then goes to WAIT_SOF, which consumes the pending SOF beat as pixel 0 of the next frame.
- Input tlast is never used. Output tuser and tlast come only from `pix`.
- frame_cnt increments on the output handshake of the beat with m_axis_tlast=1.
- TOTAL=1 is legal: that beat carries both tuser and tlast.

## Timing
- Output is registered through a 2-entry skid buffer.
- Latency: 1 cycle from input handshake to m_axis_tvalid.
- Throughput: 1 beat/cycle while m_axis_tready=1.
- s_axis_tready is a registered function of buffer occupancy and state. It has no combinational path from m_axis_tready.
- A beat held by m_axis_tvalid=1 && m_axis_tready=0 keeps tdata, tuser and tlast stable until accepted.
- Reset values:
  - m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, early_sof_err, drop_err and s_axis_tready are all 0.
  - frame_cnt=0, pix=0, state=WAIT_SOF.
  - s_axis_tready rises on the first clk edge after rst_n deasserts.
- Reset mid-frame discards buffer contents immediately. The partial frame is not completed or padded.
- Early SOF arriving on the same cycle as pixel TOTAL-1 is impossible: that cycle is already end of frame. A SOF on the following cycle is accepted normally in WAIT_SOF with no error.
- Backpressure during PAD stalls padding. No pad beat is lost or duplicated.

## Structure
- Package `axis_frame_aligner_pkg` holds:
  - the state enum `aligner_state_t` (WAIT_SOF, PASS, PAD);
  - a function computing the counter width from WIDTH and HEIGHT.
- Sub-module `axis_skid_buffer`: a parameterised 2-entry register slice carrying {tdata, tuser, tlast}, with a `full`/`ready` output for the FSM.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (TOTAL=8) and PAD_VALUE=24'h0.

- Clean frame 0x01..0x08, tuser on 0x01, m_axis_tready=1:
  - 8 output beats 0x01..0x08, tuser on beat 0, tlast on beat 7.
  - frame_cnt=1, no error pulses.
- Three junk beats (0xAA, 0xBB, 0xCC) before SOF:
  - drop_err pulses 3 times.
  - Output is identical to the clean-frame case.
- SOF, 0x02..0x05, then a new SOF 0x11 followed by 0x12..0x18:
  - early_sof_err pulses once.
  - Output is 0x01..0x05, 0x0,0x0,0x0 (tlast on the third pad), then 0x11..0x18 with tuser on 0x11.
  - frame_cnt=2.
- Clean frame with m_axis_tready toggled by random 50% backpressure:
  - Exact 8-beat sequence, each beat stable while stalled, no loss or duplication.
- Reset asserted after pixel 3, then a clean frame sent:
  - All outputs 0 during reset.
  - Post-reset output is only the new frame; frame_cnt=1.
